sram_1rw_port_ctrl: RTL and testbench

//   Front-end controller for the single-port 150b x 512 SRAM macro (csb0/web0/addr0/din0/dout0, 1RW).

---
 rtl/sram_1rw_port_ctrl.sv | 154 +++++++++++++++
 tb/tb_sram_1rw_port_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_1rw_port_ctrl.sv
// sram_1rw_port_ctrl: single-port (1RW) SRAM front-end controller.
// Merges a write and a read request channel onto the one macro port, one
// access per cycle, and returns read data through a small response FIFO.
// Optional feature macro: SRAM_CTRL_RR_EN (round-robin arbitration on
// write/read conflict). When undefined, write has fixed priority.
module sram_1rw_port_ctrl #(
  parameter int unsigned DATA_WIDTH = 150,
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned RSP_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_valid,
  output logic                  rd_ready,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout
);

  localparam int unsigned PTR_W = $clog2(RSP_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [DATA_WIDTH-1:0] fifo_mem [RSP_DEPTH];
  logic [PTR_W-1:0]      fifo_wr_ptr;
  logic [PTR_W-1:0]      fifo_rd_ptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  rd_inflight;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;
  logic                  rd_can;
  logic                  grant_wr;
  logic                  grant_rd;
  logic                  push;
  logic                  pop;

`ifdef SRAM_CTRL_RR_EN
  typedef enum logic {PREF_WR = 1'b0, PREF_RD = 1'b1} pref_e;
  pref_e rr_ptr;
`endif

  // Read admission: buffered plus in-flight reads must leave a free FIFO slot.
  assign rd_can = (OCC_W'(fifo_count) + OCC_W'(rd_inflight)) < OCC_W'(RSP_DEPTH);

  // One grant per cycle; nothing is granted while reset is asserted.
  always_comb begin
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    if (rst_n) begin
`ifdef SRAM_CTRL_RR_EN
      if (wr_valid && rd_valid && rd_can) begin
        grant_wr = (rr_ptr == PREF_WR);
        grant_rd = (rr_ptr == PREF_RD);
      end else if (wr_valid) begin
        grant_wr = 1'b1;
      end else if (rd_valid && rd_can) begin
        grant_rd = 1'b1;
      end
`else
      if (wr_valid) begin
        grant_wr = 1'b1;
      end else if (rd_valid && rd_can) begin
        grant_rd = 1'b1;
      end
`endif
    end
  end

  assign wr_ready  = grant_wr;
  assign rd_ready  = grant_rd;

  // Macro pins follow the grant; address and data hold when idle.
  assign sram_csb  = ~(grant_wr | grant_rd);
  assign sram_web  = ~grant_wr;
  assign sram_addr = grant_wr ? wr_addr : (grant_rd ? rd_addr : addr_q);
  assign sram_din  = grant_wr ? wr_data : din_q;

  assign push      = rd_inflight;
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid & rsp_ready;
  assign rsp_data  = fifo_mem[fifo_rd_ptr];

  // Hold registers so idle cycles do not toggle the macro address/data pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      din_q  <= '0;
    end else if (grant_wr) begin
      addr_q <= wr_addr;
      din_q  <= wr_data;
    end else if (grant_rd) begin
      addr_q <= rd_addr;
    end
  end

  // A read accepted this cycle has its macro output valid next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_inflight <= 1'b0;
    end else begin
      rd_inflight <= grant_rd;
    end
  end

  // Response FIFO: dout is captured exactly once, one cycle after the read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RSP_DEPTH); i++) begin
        fifo_mem[i] <= '0;
      end
      fifo_wr_ptr <= '0;
      fifo_rd_ptr <= '0;
      fifo_count  <= '0;
    end else begin
      if (push) begin
        fifo_mem[fifo_wr_ptr] <= sram_dout;
        fifo_wr_ptr           <= fifo_wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        fifo_rd_ptr <= fifo_rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef SRAM_CTRL_RR_EN
  // Round-robin pointer: point at the other channel after each granted access,
  // except when write wins only because reads are blocked by admission.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= PREF_WR;
    end else if (grant_wr && !(rd_valid && !rd_can)) begin
      rr_ptr <= PREF_RD;
    end else if (grant_rd) begin
      rr_ptr <= PREF_WR;
    end
  end
`endif

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Testbench for sram_1rw_port_ctrl: grant table, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_sram_1rw_port_ctrl;

  localparam int unsigned DW    = 150;
  localparam int unsigned AW    = 9;
  localparam int unsigned DEPTH = 2;

  logic          clk;
  logic          rst_n;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [AW-1:0] wr_addr, rd_addr, sram_addr;
  logic [DW-1:0] wr_data, rsp_data, sram_din, sram_dout;
  logic          rsp_valid, rsp_ready, sram_csb, sram_web;

  sram_1rw_port_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_pass;

  function automatic void chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [159:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return r[DW-1:0];
  endfunction

  // Content of a never-written macro word (shared by macro and model).
  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    logic [31:0] h;
    h = {23'd0, a} * 32'h9E3779B1 + 32'h01234567;
    return DW'({h, ~h, h ^ 32'hFFFF0000, h, ~h});
  endfunction

  // Behavioural 1RW macro: dout valid only in the cycle after a read.
  logic [DW-1:0] mac_mem [512];
  bit            mac_wr  [512];
  always @(posedge clk) begin
    if (!sram_csb && !sram_web) begin
      mac_mem[sram_addr] <= sram_din;
      mac_wr[sram_addr]  <= 1'b1;
      sram_dout          <= rand_word();
    end else if (!sram_csb) begin
      sram_dout <= mac_wr[sram_addr] ? mac_mem[sram_addr] : init_val(sram_addr);
    end else begin
      sram_dout <= rand_word();
    end
  end

  // Reference model: memory image plus queue of outstanding (unpopped) reads.
  typedef struct {
    logic [DW-1:0] data;
    int            acc;
  } pend_t;
  pend_t         pend[$];
  logic [DW-1:0] ref_mem [512];
  bit            ref_wr  [512];
  int            cyc;
  bit            pref_rd;
  bit            addr_known, din_known;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;

  logic          obs_wr_ready, obs_rd_ready, obs_rsp_valid, obs_csb, obs_web;
  logic [DW-1:0] obs_rsp_data;

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    pend.delete();
    pref_rd    = 1'b0;
    addr_known = 1'b0;
    din_known  = 1'b0;
  endtask

  // One clock cycle: inputs already driven; check at negedge, then advance.
  task automatic step();
    bit            can, gw, gr, rv_e;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    can = pend.size() < int'(DEPTH);
`ifdef SRAM_CTRL_RR_EN
    if (wr_valid && rd_valid && can) begin
      gw = !pref_rd;
      gr = pref_rd;
    end else begin
      gw = wr_valid;
      gr = !wr_valid && rd_valid && can;
    end
`else
    gw = wr_valid;
    gr = !wr_valid && rd_valid && can;
`endif
    rv_e = (pend.size() > 0) && (cyc - pend[0].acc >= 2);
    obs_wr_ready  = wr_ready;
    obs_rd_ready  = rd_ready;
    obs_rsp_valid = rsp_valid;
    obs_rsp_data  = rsp_data;
    obs_csb       = sram_csb;
    obs_web       = sram_web;
    chk1("wr_ready", wr_ready, gw);
    chk1("rd_ready", rd_ready, gr);
    chk1("sram_csb", sram_csb, !(gw || gr));
    chk1("sram_web", sram_web, !gw);
    chk1("rsp_valid", rsp_valid, rv_e);
    if (rv_e) chkw("rsp_data", rsp_data, pend[0].data);
    ea = gw ? wr_addr : (gr ? rd_addr : last_addr);
    if (gw || gr || addr_known) chkw("sram_addr", DW'(sram_addr), DW'(ea));
    ed = gw ? wr_data : last_din;
    if (gw || din_known) chkw("sram_din", sram_din, ed);
    if (rv_e && rsp_ready) void'(pend.pop_front());
    if (gw) begin
      ref_mem[wr_addr] = wr_data;
      ref_wr[wr_addr]  = 1'b1;
      last_addr  = wr_addr;
      last_din   = wr_data;
      addr_known = 1'b1;
      din_known  = 1'b1;
    end
    if (gr) begin
      pend.push_back('{data: ref_read(rd_addr), acc: cyc});
      last_addr  = rd_addr;
      addr_known = 1'b1;
    end
    if (!(wr_valid && rd_valid && !can)) begin
      if (gw) pref_rd = 1'b1;
      else if (gr) pref_rd = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit            wv, rv;
    bit            e_wr, e_rd, e_csb, e_web;
    logic [AW-1:0] e_addr;
  } vec_t;
  vec_t vecs[4];

  initial begin
    int  acc_n, csb_low, rsp_n;
    bit  exp_w[4];
    bit  exp_r3[6];

    vecs[0] = '{wv: 1'b1, rv: 1'b0, e_wr: 1'b1, e_rd: 1'b0, e_csb: 1'b0, e_web: 1'b0, e_addr: 9'd5};
    vecs[1] = '{wv: 1'b0, rv: 1'b1, e_wr: 1'b0, e_rd: 1'b1, e_csb: 1'b0, e_web: 1'b1, e_addr: 9'd9};
    vecs[2] = '{wv: 1'b1, rv: 1'b1, e_wr: 1'b1, e_rd: 1'b0, e_csb: 1'b0, e_web: 1'b0, e_addr: 9'd5};
    vecs[3] = '{wv: 1'b0, rv: 1'b0, e_wr: 1'b0, e_rd: 1'b0, e_csb: 1'b1, e_web: 1'b1, e_addr: 9'd0};
`ifdef SRAM_CTRL_RR_EN
    exp_w = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_w = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    exp_r3 = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    n_chk = 0; n_pass = 0; cyc = 0;
    model_reset();
    rst_n = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b0;
    wr_addr = '0; rd_addr = '0; wr_data = '0;

    // Reset state, with both requests asserted.
    #1 wr_valid = 1'b1; rd_valid = 1'b1;
    #1;
    chk1("rst_wr_ready", wr_ready, 1'b0);
    chk1("rst_rd_ready", rd_ready, 1'b0);
    chk1("rst_csb", sram_csb, 1'b1);
    chk1("rst_web", sram_web, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    chkw("rst_rsp_data", rsp_data, '0);
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Combinational grant table on an empty controller, no clock edge crossed.
    wr_addr = 9'd5; rd_addr = 9'd9; wr_data = rand_word();
    for (int i = 0; i < 4; i++) begin
      wr_valid = vecs[i].wv; rd_valid = vecs[i].rv;
      #1;
      chk1("tbl_wr_ready", wr_ready, vecs[i].e_wr);
      chk1("tbl_rd_ready", rd_ready, vecs[i].e_rd);
      chk1("tbl_csb", sram_csb, vecs[i].e_csb);
      chk1("tbl_web", sram_web, vecs[i].e_web);
      if (!vecs[i].e_csb) chkw("tbl_addr", DW'(sram_addr), DW'(vecs[i].e_addr));
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); #1;

    // Write 0x3A5 to 7, read it back 2 cycles after accept.
    rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 9'd7; wr_data = DW'(12'h3A5);
    step();
    chk1("t1_wr_csb", obs_csb, 1'b0);
    chk1("t1_wr_web", obs_web, 1'b0);
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd7;
    step();
    chk1("t1_rd_csb", obs_csb, 1'b0);
    chk1("t1_rd_web", obs_web, 1'b1);
    rd_valid = 1'b0;
    step();
    chk1("t1_rsp_early", obs_rsp_valid, 1'b0);
    step();
    chk1("t1_rsp_valid", obs_rsp_valid, 1'b1);
    chkw("t1_rsp_data", obs_rsp_data, DW'(12'h3A5));
    step();

    // Four reads to 0..3 with the consumer always ready.
    acc_n = 0; csb_low = 0; rsp_n = 0;
    rd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rd_addr = AW'(acc_n);
      step();
      if (obs_rd_ready) acc_n++;
      if (!obs_csb) csb_low++;
      if (obs_rsp_valid) rsp_n++;
      if (acc_n == 4) rd_valid = 1'b0;
    end
    chkw("t2_accepts", DW'(acc_n), DW'(4));
    chkw("t2_csb_low", DW'(csb_low), DW'(4));
    chkw("t2_responses", DW'(rsp_n), DW'(4));

    // Backpressure: only two reads admitted until a pop is seen.
    rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 9'd20;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) rsp_ready = 1'b1;
      step();
      chk1("t3_rd_ready", obs_rd_ready, exp_r3[i]);
      rd_addr = rd_addr + AW'(1);
    end
    rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset one cycle after a read accept drops it.
    rd_valid = 1'b1; rd_addr = 9'd3;
    step();
    chk1("t5_accept", obs_rd_ready, 1'b1);
    wr_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk1("t5_csb", sram_csb, 1'b1);
    chk1("t5_rsp_valid", rsp_valid, 1'b0);
    chk1("t5_wr_ready", wr_ready, 1'b0);
    chk1("t5_rd_ready", rd_ready, 1'b0);
    model_reset();
    wr_valid = 1'b0; rd_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    rsp_n = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs_rsp_valid) rsp_n++;
    end
    chkw("t5_no_rsp", DW'(rsp_n), '0);

    // Conflict for four cycles.
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; rd_valid = 1'b1;
      wr_addr = AW'(40 + i); wr_data = rand_word(); rd_addr = AW'(50 + i);
      step();
      chk1("t4_wr_grant", obs_wr_ready, exp_w[i]);
      chk1("t4_rd_grant", obs_rd_ready, !exp_w[i]);
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      wr_valid  = $urandom_range(0, 1) == 1;
      rd_valid  = $urandom_range(0, 9) < 6;
      rsp_ready = $urandom_range(0, 9) < 7;
      wr_addr   = AW'($urandom_range(0, 7));
      rd_addr   = AW'($urandom_range(0, 7));
      wr_data   = rand_word();
      step();
    end
    wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chkw("final_drain", DW'(pend.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
